gps_feed_scheduler: RTL

GPS_FEED_SCHEDULER -- requirements
Module: gps_feed_scheduler

---
 rtl/gps_feed_scheduler.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/gps_feed_scheduler.sv
`timescale 1ns/1ps
// Byte FIFO that feeds a fixed-rate {sign, mag[1:0]} sample stream; an end-of-stream
// marker byte (bit7) terminates a run. state_dbg exposes the FSM state to checkers.
module gps_feed_scheduler #(
    parameter int DEPTH     = 16,
    parameter int DIV_WIDTH = 8
) (
    input  logic                     clk_0,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [DIV_WIDTH-1:0]     div,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready,
    output logic                     sample_valid,
    output logic [2:0]               sample_data,
    output logic                     busy,
    output logic                     done,
    output logic                     underflow,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [15:0]              sample_count,
    output logic [1:0]               state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2, DONE = 2'd3} state_e;

    state_e                state_q, state_d;
    logic                  start_q;
    logic [7:0]            mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q, count_d;
    logic [AW:0]           marker_cnt_q, marker_cnt_d;
    logic [DIV_WIDTH-1:0]  tick_cnt_q, tick_cnt_d;
    logic                  sample_valid_q, sample_valid_d;
    logic [2:0]            sample_data_q, sample_data_d;
    logic                  underflow_q, underflow_d;
    logic [15:0]           sample_count_q, sample_count_d;
    logic                  flush;
    logic                  abort;
    logic                  tick;
    logic                  empty;
    logic                  wr_fire;
    logic                  pop;
    logic [7:0]            head;

    assign head     = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign abort    = ((state_q == PRIME) || (state_q == RUN)) && !start;
    assign tick     = (state_q == RUN) && (tick_cnt_q == '0) && !abort;
    // Ready drops during an abort so a byte is never accepted and then flushed.
    assign wr_ready = (count_q < FULL_LVL) && (state_q != DONE) && !abort;
    assign wr_fire  = wr_valid && wr_ready;
    assign pop      = tick && !empty;

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        marker_cnt_d   = marker_cnt_q;
        tick_cnt_d     = tick_cnt_q;
        sample_valid_d = 1'b0;
        sample_data_d  = sample_data_q;
        underflow_d    = underflow_q;
        sample_count_d = sample_count_q;
        flush          = 1'b0;

        case ({wr_fire, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case ({wr_fire && wr_data[7], pop && head[7]})
            2'b10:   marker_cnt_d = marker_cnt_q + 1'b1;
            2'b01:   marker_cnt_d = marker_cnt_q - 1'b1;
            default: marker_cnt_d = marker_cnt_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start && !start_q) begin
                    state_d        = PRIME;
                    sample_count_d = '0;
                    underflow_d    = 1'b0;
                end
            end
            PRIME: begin
                if (abort) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else if ((count_q == FULL_LVL) || (marker_cnt_q != '0) ||
                             (wr_fire && wr_data[7])) begin
                    state_d    = RUN;
                    tick_cnt_d = div;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else if (tick_cnt_q == '0) begin
                    tick_cnt_d = div;
                    if (empty) begin
                        underflow_d = 1'b1;
                    end else if (head[7]) begin
                        state_d = DONE;
                    end else begin
                        sample_valid_d = 1'b1;
                        sample_data_d  = head[2:0];
                        sample_count_d = sample_count_q + 16'd1;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            count_d      = '0;
            marker_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_0 or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            start_q        <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            marker_cnt_q   <= '0;
            tick_cnt_q     <= '0;
            sample_valid_q <= 1'b0;
            sample_data_q  <= 3'd0;
            underflow_q    <= 1'b0;
            sample_count_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            start_q        <= start;
            count_q        <= count_d;
            marker_cnt_q   <= marker_cnt_d;
            tick_cnt_q     <= tick_cnt_d;
            sample_valid_q <= sample_valid_d;
            sample_data_q  <= sample_data_d;
            underflow_q    <= underflow_d;
            sample_count_q <= sample_count_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers and occupancy alone define what is valid.
    always_ff @(posedge clk_0) begin
        if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
    end

    assign sample_valid = sample_valid_q;
    assign sample_data  = sample_data_q;
    assign busy         = (state_q == PRIME) || (state_q == RUN);
    assign done         = (state_q == DONE);
    assign underflow    = underflow_q;
    assign fill_level   = count_q;
    assign sample_count = sample_count_q;
    assign state_dbg    = state_q;

endmodule
